nn_wb_master: RTL and testbench

- Wishbone classic (B3, non-pipelined) initiator that drives the NN accelerator's Wishbone slave port: operand/weight writes, result reads.
- Accepts read/write commands from a local command port (test sequencer, management-core bridge or bench driver), buffers them in a small FIFO and executes one bus cycle at a time.
- Returns one response per command with read data, or an error flag on ack timeout.

---
 rtl/nn_wb_master.sv | 143 ++++++++++++++
 tb/tb_nn_wb_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_wb_master.sv
// nn_wb_master: Wishbone classic initiator for the NN accelerator slave port.
// Commands are queued in a small FIFO. Bus cycles run one at a time, and each
// command gets exactly one response, returned in order.
//
// state | meaning
// IDLE  | no bus cycle; pops the FIFO head when one is queued
// BUS   | cyc/stb asserted, waiting for ack or for the timeout
// RESP  | response held on rsp_*, waiting for rsp_ready
module nn_wb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // The counter holds the number of ack-less edges already seen. Aborting when
  // it reaches TIMEOUT-1 means that the strobe stays up for exactly TIMEOUT
  // cycles when no ack arrives.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state;
  logic [64:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [TO_W-1:0] to_cnt;
  logic            push;
  logic            pop;

  // cmd_ready depends only on the registered count, so a pop on the same edge
  // cannot free a slot for a push.
  assign cmd_ready = (count < (PW+1)'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign wbm_sel_o = 4'hF;
  assign busy      = (count != '0) || (state != IDLE);

  // FIFO storage; entries are {we, adr, dat}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_we, cmd_adr, cmd_dat};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bus-cycle sequencer with registered Wishbone and response outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            {wbm_we_o, wbm_adr_o, wbm_dat_o} <= mem[rd_ptr];
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            to_cnt    <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_we    <= wbm_we_o;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (to_cnt == TO_LIMIT) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_we    <= wbm_we_o;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_wb_master.sv
// Directed testbench for nn_wb_master with a simple behavioural Wishbone slave.
module tb_nn_wb_master;

  logic        clk;
  logic        rst_l;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // slave model controls
  logic        ack_en;
  logic        force_ack;
  logic        dat_from_adr;
  int          ack_wait;
  logic [31:0] rd_data;
  int          stb_cnt;

  // bus monitor
  logic        prev_stb;
  logic [31:0] prev_adr;
  logic [31:0] prev_dat;
  logic        prev_we;
  int          stb_run;
  int          last_len;
  int          n_bus;
  int          n_unstable;
  int          rsp_rises;
  logic        prev_rsp_valid;
  logic        cap_we;
  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic [3:0]  cap_sel;

  nn_wb_master dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave acks after ack_wait strobe cycles; outside the ack cycle it drives garbage data
  assign wbm_ack_i = force_ack | (ack_en & wbm_cyc_o & wbm_stb_o & (stb_cnt == ack_wait));
  assign wbm_dat_i = wbm_ack_i ? (dat_from_adr ? (wbm_adr_o + 32'h1000) : rd_data) : 32'hDEAD_BEEF;

  // slave wait counter and bus monitor
  always @(posedge clk) begin
    stb_cnt        <= (wbm_stb_o && !wbm_ack_i) ? stb_cnt + 1 : 0;
    prev_stb       <= wbm_stb_o;
    prev_adr       <= wbm_adr_o;
    prev_dat       <= wbm_dat_o;
    prev_we        <= wbm_we_o;
    prev_rsp_valid <= rsp_valid;
    if (rsp_valid && !prev_rsp_valid) rsp_rises <= rsp_rises + 1;
    if (wbm_stb_o && !prev_stb) begin
      n_bus   <= n_bus + 1;
      stb_run <= 1;
      cap_we  <= wbm_we_o;
      cap_adr <= wbm_adr_o;
      cap_dat <= wbm_dat_o;
      cap_sel <= wbm_sel_o;
    end
    if (wbm_stb_o && prev_stb) begin
      stb_run <= stb_run + 1;
      if (wbm_adr_o != prev_adr || wbm_dat_o != prev_dat || wbm_we_o != prev_we)
        n_unstable <= n_unstable + 1;
    end
    if (!wbm_stb_o && prev_stb) last_len <= stb_run;
  end

  initial begin
    stb_cnt = 0; prev_stb = 0; prev_adr = 0; prev_dat = 0; prev_we = 0;
    stb_run = 0; last_len = 0; n_bus = 0; n_unstable = 0; rsp_rises = 0;
    prev_rsp_valid = 0; cap_we = 0; cap_adr = 0; cap_dat = 0; cap_sel = 0;
  end

  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int n;
    n = 0;
    while (!cmd_ready && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end else begin
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int budget, output logic ok);
    int n;
    n = 0;
    while (!rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready=%b rsp_valid=%b busy=%b required 1 0 0", cmd_ready, rsp_valid, busy);
    end
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b adr=%h dat=%h required all 0", wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o);
    end
    checks++;
    if (rsp_we !== 1'b0 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: we=%b dat=%h err=%b required 0 0 0", rsp_we, rsp_dat, rsp_err);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_l = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic ok;
    ack_en = 1; ack_wait = 0; dat_from_adr = 0; rd_data = 32'h0;
    push_cmd(1'b1, 32'h0000_0004, 32'h3F80_0000);
    wait_rsp(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_rsp_valid: rsp_valid=%b required 1", rsp_valid); end
    checks++;
    if (rsp_we !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
      errors++;
      $display("FAIL write_rsp: we=%b err=%b dat=%h required 1 0 00000000", rsp_we, rsp_err, rsp_dat);
    end
    take_rsp();
    checks++;
    if (cap_we !== 1'b1 || cap_adr !== 32'h4 || cap_dat !== 32'h3F80_0000 || cap_sel !== 4'hF) begin
      errors++;
      $display("FAIL write_bus: we=%b adr=%h dat=%h sel=%h required 1 00000004 3f800000 f", cap_we, cap_adr, cap_dat, cap_sel);
    end
    checks++;
    if (last_len !== 1) begin errors++; $display("FAIL write_stb_len: got %0d required 1", last_len); end
  endtask

  task automatic test_read_wait();
    logic ok;
    int unst;
    unst = n_unstable;
    ack_en = 1; ack_wait = 3; dat_from_adr = 0; rd_data = 32'h4000_0000;
    push_cmd(1'b0, 32'h0000_0010, 32'h0);
    wait_rsp(50, ok);
    checks++;
    if (!ok || rsp_we !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h4000_0000) begin
      errors++;
      $display("FAIL read_rsp: valid=%b we=%b err=%b dat=%h required 1 0 0 40000000", rsp_valid, rsp_we, rsp_err, rsp_dat);
    end
    take_rsp();
    checks++;
    if (last_len !== 4 || cap_adr !== 32'h10 || n_unstable !== unst) begin
      errors++;
      $display("FAIL read_bus: stb_len=%0d adr=%h unstable=%0d required 4 00000010 %0d", last_len, cap_adr, n_unstable, unst);
    end
  endtask

  task automatic test_back_to_back();
    logic        ok;
    int          bus0;
    logic        exp_we  [5];
    logic [31:0] exp_adr [5];
    exp_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) exp_adr[i] = 32'h100 + 32'(i * 4);
    ack_en = 1; ack_wait = 0; dat_from_adr = 1;
    bus0 = n_bus;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(exp_we[i], exp_adr[i], 32'hC0DE_0000 + 32'(i));
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
    end
    // try a sixth command while full; it must not be taken
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'hFFF0; cmd_dat = 32'h0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || n_bus - bus0 !== 1 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: cmd_ready=%b bus_cycles=%0d rsp_valid=%b required 0 1 1", cmd_ready, n_bus - bus0, rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp(50, ok);
      checks++;
      if (!ok || rsp_we !== exp_we[i] || rsp_err !== 1'b0 ||
          rsp_dat !== (exp_we[i] ? 32'h0 : exp_adr[i] + 32'h1000)) begin
        errors++;
        $display("FAIL b2b_rsp%0d: valid=%b we=%b err=%b dat=%h required 1 %b 0 %h", i, rsp_valid, rsp_we, rsp_err,
                 rsp_dat, exp_we[i], exp_we[i] ? 32'h0 : exp_adr[i] + 32'h1000);
      end
      take_rsp();
    end
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    checks++;
    if (n_bus - bus0 !== 5 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: bus_cycles=%0d rsp_valid=%b busy=%b required 5 0 0", n_bus - bus0, rsp_valid, busy);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    ack_en = 0; dat_from_adr = 0;
    push_cmd(1'b0, 32'h0000_0020, 32'h0);
    wait_rsp(600, ok);
    checks++;
    if (!ok || rsp_err !== 1'b1 || rsp_dat !== 32'h0 || rsp_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rsp: valid=%b err=%b dat=%h we=%b required 1 1 00000000 0", rsp_valid, rsp_err, rsp_dat, rsp_we);
    end
    take_rsp();
    checks++;
    if (last_len !== 255) begin errors++; $display("FAIL timeout_len: got %0d required 255", last_len); end
    ack_en = 1; ack_wait = 1;
    push_cmd(1'b1, 32'h0000_0024, 32'h1111_2222);
    wait_rsp(50, ok);
    checks++;
    if (!ok || rsp_err !== 1'b0 || rsp_we !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: valid=%b err=%b we=%b required 1 0 1", rsp_valid, rsp_err, rsp_we);
    end
    take_rsp();
  endtask

  task automatic test_ack_on_timeout();
    logic ok;
    int rises;
    ack_en = 1; ack_wait = 254; dat_from_adr = 0; rd_data = 32'h1234_5678;
    push_cmd(1'b0, 32'h0000_0030, 32'h0);
    wait_rsp(600, ok);
    checks++;
    if (!ok || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_5678) begin
      errors++;
      $display("FAIL edge_ack_rsp: valid=%b err=%b dat=%h required 1 0 12345678", rsp_valid, rsp_err, rsp_dat);
    end
    take_rsp();
    checks++;
    if (last_len !== 255) begin errors++; $display("FAIL edge_ack_len: got %0d required 255", last_len); end
    rises = rsp_rises;
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    force_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rises !== rises || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: rsp_valid=%b new_rsps=%0d busy=%b required 0 0 0", rsp_valid, rsp_rises - rises, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int rises;
    int bus0;
    ack_en = 1; ack_wait = 10; dat_from_adr = 0; rd_data = 32'hAAAA_5555;
    push_cmd(1'b0, 32'h0000_0040, 32'h0);
    push_cmd(1'b1, 32'h0000_0044, 32'h1);
    push_cmd(1'b1, 32'h0000_0048, 32'h2);
    @(posedge clk); #1;
    checks++;
    if (wbm_stb_o !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: stb=%b busy=%b required 1 1", wbm_stb_o, busy);
    end
    rst_l = 1'b0;
    #2;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: cyc=%b stb=%b rsp_valid=%b required 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_l = 1'b1;
    rises = rsp_rises;
    bus0 = n_bus;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_rises !== rises || n_bus !== bus0) begin
      errors++;
      $display("FAIL midrst_after: busy=%b cmd_ready=%b new_rsps=%0d new_bus=%0d required 0 1 0 0", busy, cmd_ready,
               rsp_rises - rises, n_bus - bus0);
    end
    ack_wait = 0;
    push_cmd(1'b0, 32'h0000_0050, 32'h0);
    wait_rsp(50, ok);
    checks++;
    if (!ok || rsp_err !== 1'b0 || rsp_dat !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL midrst_recover: valid=%b err=%b dat=%h required 1 0 aaaa5555", rsp_valid, rsp_err, rsp_dat);
    end
    take_rsp();
  endtask

  initial begin
    rst_l = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    rsp_ready = 1'b0; ack_en = 1'b1; force_ack = 1'b0; dat_from_adr = 1'b0;
    ack_wait = 0; rd_data = 32'h0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
